// File: rtl/bus_timer_if.sv
// Bus device port for bus_timer: the request/response signals of one priority-bus device port.
interface bus_timer_if #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
);
  logic                      req_i;
  logic                      we_i;
  logic [DataWidth/8-1:0]    be_i;
  logic [AddressWidth-1:0]   addr_i;
  logic [DataWidth-1:0]      wdata_i;
  logic                      rvalid_o;
  logic [DataWidth-1:0]      rdata_o;
  logic                      err_o;

  modport slave  (input  req_i, we_i, be_i, addr_i, wdata_i,
                  output rvalid_o, rdata_o, err_o);
  modport master (output req_i, we_i, be_i, addr_i, wdata_i,
                  input  rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/bus_timer.sv
// 64-bit memory-mapped machine timer (mtime/mtimecmp) with level interrupt.
// Optional BUS_TIMER_HI_SNAPSHOT_EN: lo read latches hi into a shadow returned by hi reads.
module bus_timer #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned Prescale     = 1
) (
  input  logic          ck_i,
  input  logic          rst_ni,
  bus_timer_if.slave    bus,
  output logic          timer_irq_o
);
  localparam int unsigned NB = DataWidth / 8;

  logic [63:0]          mtime_q, mtime_d, mtimecmp_q, mtimecmp_d, inc;
  logic [15:0]          cnt_q, cnt_d;
  logic                 tick;
  logic                 rvalid_q, err_q, err_d, irq_q, irq_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic [7:0]           idx;
  logic                 wr, rd;
  logic [31:0]          hi_rd;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^bus.addr_i[AddressWidth-1:10];

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [NB-1:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  assign idx   = bus.addr_i[9:2];
  assign err_d = bus.req_i && ((idx > 8'd3) || (bus.addr_i[1:0] != 2'b00));
  // be_i == 0 is a plain acknowledged no-op, so it must not suppress the tick carry
  assign wr    = bus.req_i && bus.we_i && !err_d && (|bus.be_i);
  assign rd    = bus.req_i && !bus.we_i && !err_d;

`ifdef BUS_TIMER_HI_SNAPSHOT_EN
  logic [31:0] shadow_q;
  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni)                   shadow_q <= '0;
    else if (rd && idx[1:0] == 2'd0) shadow_q <= mtime_q[63:32];
  end
  assign hi_rd = shadow_q;
`else
  assign hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    tick       = (cnt_q == 16'(Prescale - 1));
    cnt_d      = tick ? 16'd0 : cnt_q + 16'd1;
    inc        = mtime_q + 64'(tick);
    mtime_d    = inc;
    mtimecmp_d = mtimecmp_q;
    // A write to one half of mtime blocks the carry across halves for that cycle
    if (wr) begin
      case (idx[1:0])
        2'd0: mtime_d = {mtime_q[63:32], merge(inc[31:0], bus.wdata_i, bus.be_i)};
        2'd1: mtime_d = {merge(mtime_q[63:32], bus.wdata_i, bus.be_i), inc[31:0]};
        2'd2: mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], bus.wdata_i, bus.be_i);
        default: mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], bus.wdata_i, bus.be_i);
      endcase
    end
    rdata_d = '0;
    if (rd) begin
      case (idx[1:0])
        2'd0:    rdata_d = mtime_q[31:0];
        2'd1:    rdata_d = hi_rd;
        2'd2:    rdata_d = mtimecmp_q[31:0];
        default: rdata_d = mtimecmp_q[63:32];
      endcase
    end
    irq_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge ck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= bus.req_i;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;
  assign timer_irq_o  = irq_q;
endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: two instances (Prescale 4 and 1) share one request stream.
module tb_bus_timer;
  logic ck = 1'b0, rst_n = 1'b0;
  always #5 ck = ~ck;

  logic        req = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        irq4, irq1;

  bus_timer_if bus4();
  bus_timer_if bus1();
  assign bus4.req_i = req;  assign bus4.we_i = we;  assign bus4.be_i = be;
  assign bus4.addr_i = addr; assign bus4.wdata_i = wdata;
  assign bus1.req_i = req;  assign bus1.we_i = we;  assign bus1.be_i = be;
  assign bus1.addr_i = addr; assign bus1.wdata_i = wdata;

  bus_timer #(.Prescale(4)) u_dut4 (.ck_i(ck), .rst_ni(rst_n), .bus(bus4), .timer_irq_o(irq4));
  bus_timer #(.Prescale(1)) u_dut1 (.ck_i(ck), .rst_ni(rst_n), .bus(bus1), .timer_irq_o(irq1));

  int vecs = 0, miss = 0;
  int ecnt, edge_n;
  logic        v4, v1, e4, e1;
  logic [31:0] d4, d1;

  // edges since reset release; edge e sees prescale counter (e-1) % Prescale
  always @(posedge ck or negedge rst_n)
    if (!rst_n) ecnt <= 0; else ecnt <= ecnt + 1;

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    edge_n = ecnt + 1;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(negedge ck);
    req = 1'b0; we = 1'b0; be = '0;
    v4 = bus4.rvalid_o; d4 = bus4.rdata_o; e4 = bus4.err_o;
    v1 = bus1.rvalid_o; d1 = bus1.rdata_o; e1 = bus1.err_o;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(2);
    vecs++;
    if ({bus1.rvalid_o, bus1.rdata_o, bus1.err_o, irq1, bus4.rvalid_o, bus4.rdata_o, bus4.err_o, irq4} !== '0) begin
      miss++; $display("FAIL reset_outputs: got v=%b d=%h e=%b irq=%b want all zero",
                       bus1.rvalid_o, bus1.rdata_o, bus1.err_o, irq1);
    end
    rst_n = 1'b1;
    issue(1'b0, 4'h0, 32'h8, 32'h0);
    vecs++;
    if (v1 !== 1'b1 || d1 !== 32'hFFFF_FFFF || e1 !== 1'b0 || v4 !== 1'b1 || d4 !== 32'hFFFF_FFFF) begin
      miss++; $display("FAIL reset_rd_cmp_lo: got v=%b d=%h e=%b want v=1 d=ffffffff e=0", v1, d1, e1);
    end
    issue(1'b0, 4'h0, 32'hC, 32'h0);
    vecs++;
    if (v1 !== 1'b1 || d1 !== 32'hFFFF_FFFF || e1 !== 1'b0 || v4 !== 1'b1 || d4 !== 32'hFFFF_FFFF) begin
      miss++; $display("FAIL reset_rd_cmp_hi: got v=%b d=%h e=%b want v=1 d=ffffffff e=0", v1, d1, e1);
    end
    idle(1);
    vecs++;
    if (bus1.rvalid_o !== 1'b0 || bus4.rvalid_o !== 1'b0 || bus1.rdata_o !== 32'h0 || irq1 !== 1'b0 || irq4 !== 1'b0) begin
      miss++; $display("FAIL rvalid_one_cycle: got v1=%b v4=%b d=%h irq=%b want 0 0 0 0",
                       bus1.rvalid_o, bus4.rvalid_o, bus1.rdata_o, irq1);
    end
  endtask

  task automatic test_prescale;
    int w_e, exp;
    issue(1'b1, 4'hF, 32'h0, 32'h0);
    w_e = edge_n;
    vecs++;
    if (v4 !== 1'b1 || d4 !== 32'h0 || e4 !== 1'b0) begin
      miss++; $display("FAIL wr_resp: got v=%b d=%h e=%b want v=1 d=0 e=0", v4, d4, e4);
    end
    idle(38);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    exp = 0;
    for (int j = w_e + 1; j <= edge_n - 1; j++) if ((j - 1) % 4 == 3) exp++;
    vecs++;
    if (d4 !== 32'(exp) || e4 !== 1'b0) begin
      miss++; $display("FAIL prescale4_lo: got %0d want %0d", d4, exp);
    end
  endtask

  task automatic test_carry;
    issue(1'b1, 4'hF, 32'h4, 32'h0);
    issue(1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF);
    idle(1);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    vecs++;
    if (d1 !== 32'h0 || e1 !== 1'b0) begin
      miss++; $display("FAIL carry_lo: got %h want 00000000", d1);
    end
    issue(1'b0, 4'h0, 32'h4, 32'h0);
    vecs++;
    if (d1 !== 32'h1 || e1 !== 1'b0) begin
      miss++; $display("FAIL carry_hi: got %h want 00000001", d1);
    end
  endtask

  task automatic test_irq;
    issue(1'b1, 4'hF, 32'hC, 32'h0);
    issue(1'b1, 4'hF, 32'h8, 32'd100);
    issue(1'b1, 4'hF, 32'h4, 32'h0);
    issue(1'b1, 4'hF, 32'h0, 32'd95);
    vecs++;
    if (irq1 !== 1'b0) begin
      miss++; $display("FAIL irq_at_95: got %b want 0", irq1);
    end
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      vecs++;
      if (irq1 !== (k >= 5)) begin
        miss++; $display("FAIL irq_ramp_%0d: got %b want %b", k, irq1, (k >= 5));
      end
    end
    issue(1'b1, 4'hF, 32'h8, 32'd200);
    vecs++;
    if (irq1 !== 1'b0 || v1 !== 1'b1 || d1 !== 32'h0 || e1 !== 1'b0) begin
      miss++; $display("FAIL irq_fall: got irq=%b v=%b d=%h e=%b want 0 1 0 0", irq1, v1, d1, e1);
    end
  endtask

  task automatic test_errors;
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    vecs++;
    if (v1 !== 1'b1 || e1 !== 1'b1 || d1 !== 32'h0 || e4 !== 1'b1) begin
      miss++; $display("FAIL err_rd_0x10: got v=%b e=%b d=%h want v=1 e=1 d=0", v1, e1, d1);
    end
    issue(1'b1, 4'hF, 32'h6, 32'hFFFF_FFFF);
    vecs++;
    if (v1 !== 1'b1 || e1 !== 1'b1 || d1 !== 32'h0) begin
      miss++; $display("FAIL err_wr_0x06: got v=%b e=%b d=%h want v=1 e=1 d=0", v1, e1, d1);
    end
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    issue(1'b0, 4'h0, 32'h4, 32'h0);
    vecs++;
    if (d1 !== 32'h0 || e1 !== 1'b0) begin
      miss++; $display("FAIL err_no_update_hi: got %h want 00000000", d1);
    end
    issue(1'b1, 4'b0010, 32'h8, 32'h0000_AB00);
    issue(1'b0, 4'h0, 32'h8, 32'h0);
    vecs++;
    if (d1 !== 32'h0000_ABC8 || d4 !== 32'h0000_ABC8) begin
      miss++; $display("FAIL byte_wr_cmp_lo: got %h want 0000abc8", d1);
    end
  endtask

  task automatic test_snapshot;
    logic [31:0] exp_hi;
`ifdef BUS_TIMER_HI_SNAPSHOT_EN
    exp_hi = 32'h1;
`else
    exp_hi = 32'h2;
`endif
    issue(1'b1, 4'hF, 32'h4, 32'h1);
    issue(1'b1, 4'hF, 32'h0, 32'hFFFF_FFF0);
    issue(1'b0, 4'h0, 32'h0, 32'h0);
    vecs++;
    if (d1 !== 32'hFFFF_FFF0) begin
      miss++; $display("FAIL snap_lo: got %h want fffffff0", d1);
    end
    idle(19);
    issue(1'b0, 4'h0, 32'h4, 32'h0);
    vecs++;
    if (d1 !== exp_hi) begin
      miss++; $display("FAIL snap_hi: got %h want %h", d1, exp_hi);
    end
  endtask

  task automatic test_reset_mid;
    req = 1'b1; we = 1'b0; addr = 32'h8;
    @(posedge ck);
    #1 rst_n = 1'b0; req = 1'b0;
    #1;
    vecs++;
    if (bus1.rvalid_o !== 1'b0 || bus1.rdata_o !== 32'h0 || irq1 !== 1'b0 || bus4.rvalid_o !== 1'b0) begin
      miss++; $display("FAIL mid_reset_drop: got v=%b d=%h irq=%b want 0 0 0", bus1.rvalid_o, bus1.rdata_o, irq1);
    end
    @(negedge ck);
    rst_n = 1'b1;
    issue(1'b0, 4'h0, 32'h8, 32'h0);
    vecs++;
    if (d1 !== 32'hFFFF_FFFF || d4 !== 32'hFFFF_FFFF) begin
      miss++; $display("FAIL mid_reset_cmp: got %h want ffffffff", d1);
    end
  endtask

  initial begin
    test_reset;
    test_prescale;
    test_carry;
    test_irq;
    test_errors;
    test_snapshot;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
